// File: rtl/rv_mem_pkg.sv
// Shared encodings for the RV32 data-memory bridge: access sizes, status
// window offsets and the load FSM state type.
package rv_mem_pkg;

  // RV32 load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access width as carried in funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Offsets inside the 4 KiB status window
  localparam logic [11:0] MMIO_STATUS = 12'h000;
  localparam logic [11:0] MMIO_CYC_LO = 12'h004;
  localparam logic [11:0] MMIO_CYC_HI = 12'h008;

  // Load FSM
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

  // Halfword on an odd byte, or word off a 4-byte boundary
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return ((sz == SZ_H) && a[0]) || (sz[1] && (a != 2'b00));
  endfunction

endpackage

// File: rtl/rv_load_align.sv
// Picks the addressed byte/half out of a DMEM word and extends it.
module rv_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  // Lane select, then sign- or zero-extend (funct3[2] marks unsigned)
  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    sext     = ~size_i[2];
    case (size_i[1:0])
      SZ_B:    data_o = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_H:    data_o = {{16{sext & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/rv_mem_bridge.sv
// M-stage to BRAM bridge: byte-lane stores, multi-cycle loads with stall,
// a small status/cycle-counter window and sticky done/misalign flags.
module rv_mem_bridge
  import rv_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter logic [31:0] DONE_ADDR  = 32'h0000_2000,
  parameter logic [31:0] DONE_MAGIC = 32'hDEAD_BEEF,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_3000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      core_addr,
  input  logic             core_re,
  input  logic             core_we,
  input  logic [2:0]       core_size,
  input  logic [31:0]      core_wdata,
  output logic [31:0]      core_rdata,
  output logic             core_stall,
  output logic [31:0]      dmem_addr,
  output logic             dmem_en,
  output logic [3:0]       dmem_we,
  output logic [31:0]      dmem_din,
  input  logic [31:0]      dmem_dout,
  output logic             done_flag,
  output logic             misalign_err,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t          state_q, state_d;
  logic [2:0]      lat_q, lat_d, lat_dec;
  logic [31:0]     rdata_q, rdata_c;
  logic            done_q, done_d, mis_q, mis_d;
  logic [CNT_W-1:0] cyc_q;
  logic [31:0]     cyc_hi, mmio_rdata, ld_data, din_c;
  logic [11:0]     off;
  logic            busy, resp, is_mmio, mis_acc;
  logic            stall_c, en_c;
  logic [3:0]      we_c;

  assign off     = core_addr[11:0];
  assign is_mmio = (core_addr[31:12] == MMIO_BASE[31:12]);
  assign mis_acc = is_misaligned(core_size[1:0], core_addr[1:0]);
  // A load is in flight in WAIT, or in the single response cycle when
  // MEM_LAT==1 (FSM stays in IDLE with a non-zero counter).
  assign busy    = (state_q == ST_WAIT) || (lat_q != 3'd0);
  assign lat_dec = lat_q - 3'd1;
  assign resp    = busy && (lat_dec == 3'd0);

  generate
    if (CNT_W > 32) begin : g_cyc_hi
      assign cyc_hi = 32'(cyc_q[CNT_W-1:32]);
    end else begin : g_cyc_hi0
      assign cyc_hi = 32'd0;
    end
  endgenerate

  rv_load_align u_align (
    .word_i (dmem_dout),
    .off_i  (core_addr[1:0]),
    .size_i (core_size),
    .data_o (ld_data)
  );

  // Status window read mux
  always_comb begin
    case (off)
      MMIO_STATUS: mmio_rdata = {30'b0, mis_q, done_q};
      MMIO_CYC_LO: mmio_rdata = cyc_q[31:0];
      MMIO_CYC_HI: mmio_rdata = cyc_hi;
      default:     mmio_rdata = 32'd0;
    endcase
  end

  // Lane replication of store data
  always_comb begin
    case (core_size[1:0])
      SZ_B:    din_c = {4{core_wdata[7:0]}};
      SZ_H:    din_c = {2{core_wdata[15:0]}};
      default: din_c = core_wdata;
    endcase
  end

  // Request decode and load FSM; stores win over loads, and request
  // changes are ignored while a load is outstanding.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    rdata_c = rdata_q;
    done_d  = done_q;
    mis_d   = mis_q;
    stall_c = 1'b0;
    en_c    = 1'b0;
    we_c    = 4'b0000;
    if (busy) begin
      if (resp) begin
        rdata_c = ld_data;
        lat_d   = 3'd0;
        state_d = ST_IDLE;
      end else begin
        stall_c = 1'b1;
        lat_d   = lat_dec;
        state_d = ST_WAIT;
      end
    end else if (core_we) begin
      if (mis_acc) begin
        mis_d = 1'b1;
      end else if (is_mmio) begin
        if ((off == MMIO_STATUS) && core_wdata[1]) mis_d = 1'b0;
      end else begin
        en_c = 1'b1;
        case (core_size[1:0])
          SZ_B:    we_c = 4'b0001 << core_addr[1:0];
          SZ_H:    we_c = 4'b0011 << core_addr[1:0];
          default: we_c = 4'b1111;
        endcase
        if ((core_size[1:0] == SZ_W) && (core_addr == DONE_ADDR) &&
            (core_wdata == DONE_MAGIC))
          done_d = 1'b1;
      end
    end else if (core_re) begin
      if (mis_acc) begin
        mis_d   = 1'b1;
        rdata_c = 32'd0;
      end else if (is_mmio) begin
        rdata_c = mmio_rdata;
      end else begin
        en_c    = 1'b1;
        stall_c = 1'b1;
        lat_d   = LAT;
        state_d = (MEM_LAT > 1) ? ST_WAIT : ST_IDLE;
      end
    end
  end

  // State, flags, held read data and the free-running cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lat_q   <= 3'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_c;
      done_q  <= done_d;
      mis_q   <= mis_d;
      if (!done_q) cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  // Combinational outputs are forced quiet while reset is held
  assign core_stall   = rst_n & stall_c;
  assign dmem_en      = rst_n & en_c;
  assign dmem_we      = rst_n ? we_c : 4'b0000;
  assign core_rdata   = rst_n ? rdata_c : 32'd0;
  assign dmem_addr    = {core_addr[31:2], 2'b00};
  assign dmem_din     = din_c;
  assign done_flag    = done_q;
  assign misalign_err = mis_q;
  assign cycle_count  = cyc_q;

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Bench for rv_mem_bridge: instance 0 (MEM_LAT=3) gets directed and random
// traffic against a byte-addressed reference memory; instance 1 (MEM_LAT=4)
// covers reset during an outstanding load.
module tb_rv_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn  [2];
  logic        re    [2];
  logic        we    [2];
  logic [2:0]  size  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic [31:0] daddr [2];
  logic        den   [2];
  logic [3:0]  dwe   [2];
  logic [31:0] ddin  [2];
  logic        done  [2];
  logic        mis   [2];
  logic [31:0] cyc   [2];

  int checks = 0;
  int errors = 0;
  logic        exp_done = 1'b0;
  logic        exp_mis  = 1'b0;
  logic [31:0] mcyc;
  logic [7:0]  rb [1024];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 3 : 4;
    logic [31:0] mem [256];
    logic [31:0] dout;
    logic [31:0] pend;
    int left = 0;

    rv_mem_bridge #(.MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rstn[g]), .core_addr(addr[g]), .core_re(re[g]),
      .core_we(we[g]), .core_size(size[g]), .core_wdata(wdata[g]),
      .core_rdata(rdata[g]), .core_stall(stall[g]), .dmem_addr(daddr[g]),
      .dmem_en(den[g]), .dmem_we(dwe[g]), .dmem_din(ddin[g]),
      .dmem_dout(dout), .done_flag(done[g]), .misalign_err(mis[g]),
      .cycle_count(cyc[g])
    );

    // BRAM model: read data appears LAT cycles after the enable and holds
    always @(posedge clk) begin
      if (den[g] && dwe[g] != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (dwe[g][b]) mem[daddr[g][9:2]][8*b +: 8] <= ddin[g][8*b +: 8];
      end else if (den[g]) begin
        pend <= mem[daddr[g][9:2]];
        left <= LAT - 1;
      end else if (left != 0) begin
        left <= left - 1;
        if (left == 1) dout <= pend;
      end
    end
  end

  // Expected cycle count: edges since reset release until done is seen
  always @(posedge clk or negedge rstn[0]) begin
    if (!rstn[0]) mcyc <= 32'd0;
    else if (!exp_done) mcyc <= mcyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  // One core access starting at posedge+1; returns first-cycle DMEM
  // signals, stall cycle count and the read data seen when stall drops.
  task automatic op(input int s, input logic r, input logic w, input logic [2:0] sz,
                    input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] rd, output int nst, output logic en0,
                    output logic [3:0] we0, output logic [31:0] din0);
    re[s] = r; we[s] = w; size[s] = sz; addr[s] = a; wdata[s] = wd;
    nst = 0;
    @(negedge clk);
    en0 = den[s]; we0 = dwe[s]; din0 = ddin[s];
    while (stall[s] === 1'b1 && nst < 16) begin
      nst++;
      @(negedge clk);
    end
    rd = rdata[s];
    @(posedge clk);
    #1;
    re[s] = 1'b0; we[s] = 1'b0;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input bit sgn);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rb[(a + i) & 32'h3FF];
    if (sgn && v[8*nb-1]) for (int i = nb*8; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  logic [31:0] rd, din0, c_saved;
  logic        en0;
  logic [3:0]  we0;
  int          nst;
  logic [2:0]  f3s [8] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rstn[s] = 1'b0; re[s] = 1'b0; we[s] = 1'b0; size[s] = 3'b010;
      addr[s] = 32'h100; wdata[s] = 32'd0;
    end
    re[0] = 1'b1;                       // load held during reset must stay quiet
    #12;
    chk("rst_stall", stall[0], 0);
    chk("rst_rdata", rdata[0], 0);
    chk("rst_en", den[0], 0);
    chk("rst_we", dwe[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_mis", mis[0], 0);
    chk("rst_cyc", cyc[0], 0);
    re[0] = 1'b0;
    @(negedge clk);
    rstn[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Cycle counter via status window after 10 cycles
    op(0, 1, 0, 3'b010, 32'h3004, 0, rd, nst, en0, we0, din0);
    chk("mmio_cyc10", rd, 10);
    chk("mmio_cyc10_nst", nst, 0);
    chk("mmio_cyc10_en", en0, 0);

    // Word store then 3-cycle load
    op(0, 0, 1, 3'b010, 32'h100, 32'h12345678, rd, nst, en0, we0, din0);
    chk("sw_en", en0, 1); chk("sw_we", we0, 4'b1111);
    chk("sw_din", din0, 32'h12345678); chk("sw_nst", nst, 0);
    op(0, 1, 0, 3'b010, 32'h100, 0, rd, nst, en0, we0, din0);
    chk("lw_en", en0, 1); chk("lw_nst", nst, 3); chk("lw_rd", rd, 32'h12345678);
    @(negedge clk);
    chk("idle_en", den[0], 0); chk("idle_we", dwe[0], 0);
    chk("idle_hold", rdata[0], 32'h12345678);
    @(posedge clk); #1;

    // Byte store and signed/unsigned byte loads
    op(0, 0, 1, 3'b000, 32'h103, 32'h000000AB, rd, nst, en0, we0, din0);
    chk("sb_we", we0, 4'b1000); chk("sb_din", din0, 32'hABABABAB);
    op(0, 1, 0, 3'b000, 32'h103, 0, rd, nst, en0, we0, din0);
    chk("lb_rd", rd, 32'hFFFFFFAB); chk("lb_nst", nst, 3);
    op(0, 1, 0, 3'b100, 32'h103, 0, rd, nst, en0, we0, din0);
    chk("lbu_rd", rd, 32'h000000AB);
    op(0, 0, 1, 3'b001, 32'h100, 32'h00009876, rd, nst, en0, we0, din0);
    chk("sh_we", we0, 4'b0011); chk("sh_din", din0, 32'h98769876);
    op(0, 1, 0, 3'b001, 32'h100, 0, rd, nst, en0, we0, din0);
    chk("lh_rd", rd, 32'hFFFF9876);
    op(0, 1, 0, 3'b101, 32'h102, 0, rd, nst, en0, we0, din0);
    chk("lhu_rd", rd, 32'h0000AB34);

    // re and we together: store only
    op(0, 1, 1, 3'b010, 32'h104, 32'h0BADF00D, rd, nst, en0, we0, din0);
    chk("both_nst", nst, 0); chk("both_we", we0, 4'b1111);
    op(0, 1, 0, 3'b010, 32'h104, 0, rd, nst, en0, we0, din0);
    chk("both_rd", rd, 32'h0BADF00D);

    // Misalignment and clearing it through the status window
    op(0, 1, 0, 3'b010, 32'h102, 0, rd, nst, en0, we0, din0);
    chk("mis_lw_en", en0, 0); chk("mis_lw_rd", rd, 0); chk("mis_lw_nst", nst, 0);
    chk("mis_flag", mis[0], 1);
    op(0, 0, 1, 3'b001, 32'h101, 32'h1234, rd, nst, en0, we0, din0);
    chk("mis_sh_en", en0, 0); chk("mis_sh_we", we0, 0);
    op(0, 1, 0, 3'b010, 32'h3000, 0, rd, nst, en0, we0, din0);
    chk("status_mis", rd, 32'h2);
    op(0, 0, 1, 3'b010, 32'h3000, 32'h2, rd, nst, en0, we0, din0);
    chk("mmio_st_en", en0, 0); chk("mmio_st_we", we0, 0);
    chk("mis_clr", mis[0], 0);
    op(0, 1, 0, 3'b010, 32'h3008, 0, rd, nst, en0, we0, din0);
    chk("mmio_hi", rd, 0);
    op(0, 1, 0, 3'b010, 32'h300C, 0, rd, nst, en0, we0, din0);
    chk("mmio_other", rd, 0);
    chk("cyc_model", cyc[0], mcyc);

    // Random traffic against the byte-level reference memory
    for (int w = 0; w < 16; w++) begin
      logic [31:0] d;
      d = $urandom();
      op(0, 0, 1, 3'b010, 32'h100 + 4*w, d, rd, nst, en0, we0, din0);
      for (int i = 0; i < 4; i++) rb[32'h100 + 4*w + i] = d[8*i +: 8];
    end
    exp_mis = 1'b0;
    for (int n = 0; n < 80; n++) begin
      int k, nb;
      logic [2:0] f3;
      logic [31:0] a, wd, dexp, bm;
      logic [3:0] m;
      bit misa;
      k = $urandom_range(0, 8);
      if (k == 8) begin
        if ($urandom_range(0, 1) == 1) begin
          op(0, 0, 1, 3'b010, 32'h3000, 32'h2, rd, nst, en0, we0, din0);
          exp_mis = 1'b0;
        end else begin
          op(0, 1, 0, 3'b010, 32'h3000, 0, rd, nst, en0, we0, din0);
          chk("rnd_status", rd, {30'b0, exp_mis, exp_done});
          chk("rnd_status_nst", nst, 0);
        end
      end else begin
        f3 = f3s[k];
        nb = 1 << f3[1:0];
        a = 32'h100 + $urandom_range(0, 63);
        wd = $urandom();
        misa = (a % nb) != 0;
        if (k < 3) begin
          op(0, 1'($urandom_range(0, 1)), 1, f3, a, wd, rd, nst, en0, we0, din0);
          chk("rnd_st_nst", nst, 0);
          if (misa) begin
            exp_mis = 1'b1;
            chk("rnd_st_mis_en", en0, 0); chk("rnd_st_mis_we", we0, 0);
          end else begin
            m = 4'b0; dexp = 32'd0; bm = 32'd0;
            for (int i = 0; i < nb; i++) begin
              int l;
              l = int'((a + i) % 4);
              m[l] = 1'b1;
              bm[8*l +: 8] = 8'hFF;
              dexp[8*l +: 8] = wd[8*i +: 8];
              rb[(a + i) & 32'h3FF] = wd[8*i +: 8];
            end
            chk("rnd_st_en", en0, 1); chk("rnd_st_we", we0, m);
            chk("rnd_st_din", din0 & bm, dexp);
          end
        end else begin
          op(0, 1, 0, f3, a, 0, rd, nst, en0, we0, din0);
          if (misa) begin
            exp_mis = 1'b1;
            chk("rnd_ld_mis_rd", rd, 0); chk("rnd_ld_mis_nst", nst, 0);
            chk("rnd_ld_mis_en", en0, 0);
          end else begin
            chk("rnd_ld_rd", rd, ref_load(a, nb, !f3[2]));
            chk("rnd_ld_nst", nst, 3);
          end
        end
        chk("rnd_mis_flag", mis[0], exp_mis);
      end
    end

    // Completion detection
    op(0, 0, 1, 3'b010, 32'h3000, 32'h2, rd, nst, en0, we0, din0);
    op(0, 0, 1, 3'b010, 32'h2000, 32'hDEADBEEE, rd, nst, en0, we0, din0);
    chk("done_wrong_magic", done[0], 0);
    op(0, 0, 1, 3'b010, 32'h2000, 32'hDEADBEEF, rd, nst, en0, we0, din0);
    chk("done_st_en", en0, 1); chk("done_st_we", we0, 4'b1111);
    chk("done_set", done[0], 1);
    exp_done = 1'b1;
    chk("done_cyc_model", cyc[0], mcyc);
    c_saved = cyc[0];
    repeat (5) @(posedge clk);
    #1;
    chk("cyc_frozen", cyc[0], c_saved);
    op(0, 1, 0, 3'b010, 32'h3000, 0, rd, nst, en0, we0, din0);
    chk("status_done", rd, 32'h1);
    op(0, 1, 0, 3'b010, 32'h2000, 0, rd, nst, en0, we0, din0);
    chk("done_word_rd", rd, 32'hDEADBEEF); chk("done_word_nst", nst, 3);

    // MEM_LAT=4 instance: first-edge acceptance, then reset mid-load
    rstn[1] = 1'b1;
    #1;
    chk("l4_idle_stall", stall[1], 0);
    op(1, 0, 1, 3'b010, 32'h100, 32'h11111111, rd, nst, en0, we0, din0);
    chk("l4_first_we", we0, 4'b1111);
    op(1, 1, 0, 3'b010, 32'h100, 0, rd, nst, en0, we0, din0);
    chk("l4_lw_nst", nst, 4); chk("l4_lw_rd", rd, 32'h11111111);
    re[1] = 1'b1; we[1] = 1'b0; size[1] = 3'b010; addr[1] = 32'h100;
    @(negedge clk);
    chk("l4_req_stall", stall[1], 1);
    @(negedge clk);
    @(negedge clk);
    chk("l4_wait2_stall", stall[1], 1);
    rstn[1] = 1'b0;
    #1;
    chk("l4_rst_stall", stall[1], 0);
    chk("l4_rst_rdata", rdata[1], 0);
    chk("l4_rst_en", den[1], 0);
    re[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rstn[1] = 1'b1;
    #1;
    chk("l4_rel_stall", stall[1], 0);
    op(1, 0, 1, 3'b010, 32'h100, 32'h5A5A5A5A, rd, nst, en0, we0, din0);
    op(1, 1, 0, 3'b010, 32'h100, 0, rd, nst, en0, we0, din0);
    chk("l4_fresh_nst", nst, 4); chk("l4_fresh_rd", rd, 32'h5A5A5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
